// File: rtl/qspi_bus_arbiter.sv
// Two-requester QSPI pin-set arbiter with chip-select guard time and bounded fairness.
// Optional: define SPI_ARB_TIMEOUT_EN to bound m1 tenure to TIMEOUT_CYCLES (forced revoke + lock).
module qspi_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned FAIR_LIMIT     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req_i,
    output logic       m0_gnt_o,
    input  logic       m0_spi_clk_i,
    input  logic       m0_spi_sel_i,
    input  logic [3:0] m0_spi_d_out_i,
    input  logic [3:0] m0_spi_d_dir_i,
    output logic [3:0] m0_spi_d_in_o,
    input  logic       m1_req_i,
    output logic       m1_gnt_o,
    input  logic       m1_spi_clk_i,
    input  logic       m1_spi_sel_i,
    input  logic [3:0] m1_spi_d_out_i,
    input  logic [3:0] m1_spi_d_dir_i,
    output logic [3:0] m1_spi_d_in_o,
    output logic       spi_clk_o,
    output logic       spi_sel_o,
    output logic [3:0] spi_d_out_o,
    output logic [3:0] spi_d_dir_o,
    input  logic [3:0] spi_d_in_i,
    output logic [1:0] owner_o,
    output logic       m1_timeout_o
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_e;

    typedef struct packed {
        logic       clk;
        logic       sel;
        logic [3:0] d_out;
        logic [3:0] d_dir;
    } pins_t;

    localparam logic [3:0] GUARD_LD = 4'(GUARD_CYCLES);
    localparam logic [3:0] GUARD_RL = 4'(GUARD_CYCLES - 1);
    localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);
    localparam pins_t      PINS_IDLE = '{clk: 1'b0, sel: 1'b1, d_out: 4'h0, d_dir: 4'h0};

    state_e     state_q;
    logic [3:0] guard_q;
    logic [3:0] fair_q;
    logic       m0_gnt_q, m1_gnt_q, m1_timeout_q, m1_lock_q;
    logic [1:0] owner_q;

    logic fair_hit, m1_wait, pick0, pick1, tmo_hit;
    pins_t m0_pins, m1_pins, bus;

    // A locked m1 is not really waiting, so it must not block m0 via the fairness rule.
    assign fair_hit = (fair_q == FAIR_MAX);
    assign m1_wait  = m1_req_i && !m1_lock_q;
    assign pick0    = m0_req_i && !(m1_wait && fair_hit);
    assign pick1    = m1_wait && (!m0_req_i || fair_hit);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [16:0] TEN_MAX = 17'(TIMEOUT_CYCLES - 1);
    logic [16:0] ten_q;

    assign tmo_hit = (state_q == OWN1) && (ten_q == TEN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ten_q <= '0;
        else if (state_q != OWN1)  ten_q <= '0;
        else                       ten_q <= ten_q + 17'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= GUARD;
            guard_q      <= GUARD_LD;
            fair_q       <= '0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            owner_q      <= 2'd0;
            m1_timeout_q <= 1'b0;
            m1_lock_q    <= 1'b0;
        end else begin
            m1_timeout_q <= 1'b0;
            if (!m1_req_i) m1_lock_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick0) begin
                        state_q  <= OWN0;
                        m0_gnt_q <= 1'b1;
                        owner_q  <= 2'd1;
                        if (m1_req_i && !fair_hit) fair_q <= fair_q + 4'd1;
                    end else if (pick1) begin
                        state_q  <= OWN1;
                        m1_gnt_q <= 1'b1;
                        owner_q  <= 2'd2;
                        fair_q   <= '0;
                    end
                end
                OWN0: begin
                    if (!m0_req_i) begin
                        state_q  <= GUARD;
                        guard_q  <= GUARD_RL;
                        m0_gnt_q <= 1'b0;
                        owner_q  <= 2'd0;
                    end
                end
                OWN1: begin
                    if (!m1_req_i || tmo_hit) begin
                        state_q  <= GUARD;
                        guard_q  <= GUARD_RL;
                        m1_gnt_q <= 1'b0;
                        owner_q  <= 2'd0;
                    end
                    if (m1_req_i && tmo_hit) begin
                        m1_timeout_q <= 1'b1;
                        m1_lock_q    <= 1'b1;
                    end
                end
                GUARD: begin
                    if (guard_q == 4'd0) state_q <= IDLE;
                    else                 guard_q <= guard_q - 4'd1;
                end
                default: state_q <= GUARD;
            endcase
            if (!m1_req_i) fair_q <= '0;
        end
    end

    // Pins follow the registered state directly; idle/guard parks cs high.
    assign m0_pins = '{clk: m0_spi_clk_i, sel: m0_spi_sel_i, d_out: m0_spi_d_out_i, d_dir: m0_spi_d_dir_i};
    assign m1_pins = '{clk: m1_spi_clk_i, sel: m1_spi_sel_i, d_out: m1_spi_d_out_i, d_dir: m1_spi_d_dir_i};

    always_comb begin
        bus = PINS_IDLE;
        case (state_q)
            OWN0:    bus = m0_pins;
            OWN1:    bus = m1_pins;
            default: bus = PINS_IDLE;
        endcase
    end

    assign spi_clk_o     = bus.clk;
    assign spi_sel_o     = bus.sel;
    assign spi_d_out_o   = bus.d_out;
    assign spi_d_dir_o   = bus.d_dir;
    assign m0_spi_d_in_o = spi_d_in_i;
    assign m1_spi_d_in_o = spi_d_in_i;
    assign m0_gnt_o      = m0_gnt_q;
    assign m1_gnt_o      = m1_gnt_q;
    assign owner_o       = owner_q;
    assign m1_timeout_o  = m1_timeout_q;
endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Scoreboard bench for qspi_bus_arbiter: a timestamp-based ownership model predicts grants/owner/
// timeout per edge; a negedge monitor compares them and the pin mux. Honours SPI_ARB_TIMEOUT_EN.
module tb_qspi_bus_arbiter;
    localparam int GUARD = 4;
    localparam int FAIR  = 3;
    localparam int TMO   = 64;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m1_req, m0_spi_clk, m0_spi_sel, m1_spi_clk, m1_spi_sel;
    logic [3:0] m0_spi_d_out, m0_spi_d_dir, m1_spi_d_out, m1_spi_d_dir, spi_d_in;
    logic       m0_gnt, m1_gnt, spi_clk, spi_sel, m1_timeout;
    logic [3:0] spi_d_out, spi_d_dir, m0_spi_d_in, m1_spi_d_in;
    logic [1:0] owner;

    int tests = 0;
    int fails = 0;
    bit rand_pins = 1'b1;

    typedef struct packed { logic g0; logic g1; logic [1:0] own; logic tmo; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    qspi_bus_arbiter #(.GUARD_CYCLES(GUARD), .FAIR_LIMIT(FAIR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_spi_clk_i(m0_spi_clk), .m0_spi_sel_i(m0_spi_sel),
        .m0_spi_d_out_i(m0_spi_d_out), .m0_spi_d_dir_i(m0_spi_d_dir), .m0_spi_d_in_o(m0_spi_d_in),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_spi_clk_i(m1_spi_clk), .m1_spi_sel_i(m1_spi_sel),
        .m1_spi_d_out_i(m1_spi_d_out), .m1_spi_d_dir_i(m1_spi_d_dir), .m1_spi_d_in_o(m1_spi_d_in),
        .spi_clk_o(spi_clk), .spi_sel_o(spi_sel), .spi_d_out_o(spi_d_out), .spi_d_dir_o(spi_d_dir),
        .spi_d_in_i(spi_d_in), .owner_o(owner), .m1_timeout_o(m1_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rst(input string name);
        check(name, 32'({m0_gnt, m1_gnt, owner, m1_timeout, spi_sel, spi_clk, spi_d_out, spi_d_dir}),
              32'({1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit which, input int bound, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (edges < bound && !(which ? m1_gnt : m0_gnt));
    endtask

    // Background pin noise, so the mux is exercised with changing values every cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_pins) begin
            {m0_spi_clk, m0_spi_sel, m0_spi_d_out, m0_spi_d_dir} = 10'($urandom);
            {m1_spi_clk, m1_spi_sel, m1_spi_d_out, m1_spi_d_dir} = 10'($urandom);
            spi_d_in = 4'($urandom);
        end
    end

    // Reference model: owner plus "bus free from edge N" timestamps; reset costs one extra guard edge.
    initial begin : model
        int cyc, free_at, own, streak, t0;
        bit locked, tmo, m1w;
        exp_t e;
        cyc = 0; free_at = GUARD + 2; own = 0; streak = 0; t0 = 0; locked = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0; free_at = GUARD + 2; own = 0; streak = 0; t0 = 0; locked = 0;
                sb.delete();
            end else begin
                cyc++;
                tmo = 1'b0;
                if (own == 1 && !m0_req) begin
                    own = 0; free_at = cyc + GUARD + 1;
                end else if (own == 2 && (!m1_req || (TMO_EN && cyc - t0 >= TMO))) begin
                    tmo = m1_req; locked = m1_req; own = 0; free_at = cyc + GUARD + 1;
                end else if (own == 0 && cyc >= free_at) begin
                    m1w = m1_req && !locked;
                    if (m1w && (!m0_req || streak == FAIR)) begin
                        own = 2; t0 = cyc; streak = 0;
                    end else if (m0_req) begin
                        own = 1;
                        if (m1_req && streak < FAIR) streak++;
                    end
                end
                if (!m1_req) begin streak = 0; locked = 0; end
                e.g0 = (own == 1); e.g1 = (own == 2); e.own = 2'(own); e.tmo = tmo;
                sb.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic [9:0] pins;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                case (e.own)
                    2'd1:    pins = {m0_spi_clk, m0_spi_sel, m0_spi_d_out, m0_spi_d_dir};
                    2'd2:    pins = {m1_spi_clk, m1_spi_sel, m1_spi_d_out, m1_spi_d_dir};
                    default: pins = {1'b0, 1'b1, 4'h0, 4'h0};
                endcase
                check("cycle", 32'({m0_gnt, m1_gnt, owner, m1_timeout, spi_clk, spi_sel, spi_d_out, spi_d_dir,
                                    m0_spi_d_in, m1_spi_d_in}),
                               32'({e.g0, e.g1, e.own, e.tmo, pins, spi_d_in, spi_d_in}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e, n0, n1, gc, tp;
        rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        {m0_spi_clk, m0_spi_sel, m0_spi_d_out, m0_spi_d_dir} = '0;
        {m1_spi_clk, m1_spi_sel, m1_spi_d_out, m1_spi_d_dir} = '0;
        spi_d_in = 4'h0;
        #2 rst_n = 1'b0;
        #1 check_rst("rst_async");
        tick(); tick();
        m0_req = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_gnt(1'b0, 20, e);
        check("rst_to_m0_gnt_edges", 32'(e), 32'd6);

        // Release with the owner's cs low, then guard, then simultaneous requests.
        rand_pins = 1'b0;
        {m0_spi_clk, m0_spi_sel, m0_spi_d_out, m0_spi_d_dir} = {1'b1, 1'b0, 4'h5, 4'hF};
        {m1_spi_clk, m1_spi_sel, m1_spi_d_out, m1_spi_d_dir} = {1'b1, 1'b0, 4'h3, 4'hF};
        m0_req = 1'b0;
        tick();
        check("release_cs_high", 32'({m0_gnt, spi_sel}), 32'({1'b0, 1'b1}));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("guard_pins", 32'({spi_sel, spi_d_dir}), 32'({1'b1, 4'h0}));
        end
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        check("both_req_m0_wins", 32'({m0_gnt, m1_gnt}), 32'({1'b1, 1'b0}));
        m0_req = 1'b0;
        wait_gnt(1'b1, 20, e);
        check("m1_gnt_edges_from_drop", 32'(e), 32'd6);
        check("own1_pins", 32'({spi_clk, spi_sel, spi_d_out, spi_d_dir}), 32'({1'b1, 1'b0, 4'h3, 4'hF}));

        // Fairness: m1 waits throughout, m0 keeps coming back.
        m1_req = 1'b0;
        repeat (10) tick();
        n0 = 0; n1 = 0;
        m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m0_req = 1'b1;
            e = 0;
            do begin tick(); e++; end while (e < 20 && !(m0_gnt || m1_gnt));
            if (m0_gnt) begin
                n0++;
                m0_req = 1'b0;
                tick();
            end else if (m1_gnt) begin
                n1++;
            end
        end
        check("fair_m0_grants", 32'(n0), 32'd3);
        check("fair_m1_on_4th", 32'({n1[7:0], m0_req, m1_gnt}), 32'({8'd1, 1'b1, 1'b1}));

        // Only the owner reaches the pins; d_in fans out to both.
        {m0_spi_clk, m0_spi_d_out, m0_spi_d_dir} = {1'b1, 4'h5, 4'hF};
        {m1_spi_clk, m1_spi_sel, m1_spi_d_out, m1_spi_d_dir} = {1'b0, 1'b0, 4'h3, 4'h2};
        for (int i = 0; i < 4; i++) begin
            m0_spi_sel = i[0];
            tick();
            check("own1_visibility", 32'({spi_clk, spi_sel, spi_d_out, spi_d_dir}), 32'({1'b0, 1'b0, 4'h3, 4'h2}));
        end
        spi_d_in = 4'hA;
        #1 check("d_in_fanout", 32'({m0_spi_d_in, m1_spi_d_in}), 32'h0000_00AA);

        // Reset while m1 owns the bus with cs low.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_rst("rst_mid_own1");
        m0_req = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        rand_pins = 1'b1;

        // Long m1 tenure.
        wait_gnt(1'b1, 20, e);
        check("m1_gnt_after_rst_edges", 32'(e), 32'd6);
        gc = 0; tp = 0;
        for (int i = 0; i < 100; i++) begin
            gc += int'(m1_gnt);
            tp += int'(m1_timeout);
            tick();
        end
        check("m1_tenure_cycles", 32'(gc), TMO_EN ? 32'd64 : 32'd100);
        check("m1_timeout_pulses", 32'(tp), TMO_EN ? 32'd1 : 32'd0);
        check("m1_locked_while_req", 32'(m1_gnt), TMO_EN ? 32'd0 : 32'd1);
        m1_req = 1'b0;
        tick();
        m1_req = 1'b1;
        wait_gnt(1'b1, 20, e);
        check("m1_regrant_after_drop", 32'(m1_gnt), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) m0_req = ~m0_req;
            if ($urandom_range(7) == 0) m1_req = ~m1_req;
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
